// File: rtl/instr_fetch_if.sv
// Bundle of the fetch unit's handshake/bus signals.
//   Memory request : mem_req_valid/mem_req_ready/mem_req_addr (valid/ready)
//   Memory response: mem_rsp_valid/mem_rsp_data (one per accepted request, in order)
//   Decode side    : instr_valid/instr_ready/instr_data/instr_pc (FIFO head)
//   Control flow   : redirect_valid/redirect_pc (single-cycle pulse)
// The master modport is the fetch unit; the slave modport is the memory,
// decode and redirect environment around it.
interface instr_fetch_if #(
  parameter int XLEN = 32
);
  logic            mem_req_valid;
  logic            mem_req_ready;
  logic [XLEN-1:0] mem_req_addr;
  logic            mem_rsp_valid;
  logic [31:0]     mem_rsp_data;
  logic            instr_valid;
  logic            instr_ready;
  logic [31:0]     instr_data;
  logic [XLEN-1:0] instr_pc;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;

  modport master (
    output mem_req_valid, mem_req_addr, instr_valid, instr_data, instr_pc,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data, instr_ready,
           redirect_valid, redirect_pc
  );

  modport slave (
    input  mem_req_valid, mem_req_addr, instr_valid, instr_data, instr_pc,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data, instr_ready,
           redirect_valid, redirect_pc
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end for the multicycle RISC-V core.
// Owns the fetch PC, issues one word read at a time over the memory port,
// and queues fetched {pc, instruction} pairs in a DEPTH-entry FIFO for decode.
// A redirect flushes the FIFO and retargets the fetch PC; a response for a
// request accepted before the redirect is dropped in DRAIN.
// Ports:
//   clk    - clock, rising edge
//   rst_n  - asynchronous active-low reset
//   bus    - instr_fetch_if.master (memory port, decode port, redirect)
// The bus interface instance must use the same XLEN as this module.
module instr_fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0001_0000,
  parameter int              DEPTH    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  instr_fetch_if.master bus
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } state_e;

  state_e           state_q;
  logic [XLEN-1:0]  fetchPc_q;
  logic [XLEN-1:0]  reqPc_q;
  logic [PTR_W-1:0] rdPtr_q;
  logic [PTR_W-1:0] wrPtr_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic [31:0]      dataMem_q [DEPTH];
  logic [XLEN-1:0]  pcMem_q   [DEPTH];

  logic accept;
  logic rspValid;
  logic push;
  logic pop;

  assign accept   = (state_q == REQ) && bus.mem_req_ready;
  // Responses only mean something while a request is outstanding.
  assign rspValid = bus.mem_rsp_valid && ((state_q == WAIT) || (state_q == DRAIN));
  // A response landing together with a redirect belongs to the old stream.
  assign push     = (state_q == WAIT) && bus.mem_rsp_valid && !bus.redirect_valid;
  assign pop      = (count_q != '0) && bus.instr_ready;

  always_comb begin
    count_d = count_q;
    if (bus.redirect_valid) begin
      count_d = '0;
    end else begin
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // All outputs come straight from registers.
  assign bus.mem_req_valid = (state_q == REQ);
  assign bus.mem_req_addr  = fetchPc_q;
  assign bus.instr_valid   = (count_q != '0);
  assign bus.instr_data    = dataMem_q[rdPtr_q];
  assign bus.instr_pc      = pcMem_q[rdPtr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      fetchPc_q <= RESET_PC;
      reqPc_q   <= '0;
      rdPtr_q   <= '0;
      wrPtr_q   <= '0;
      count_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        dataMem_q[i] <= '0;
        pcMem_q[i]   <= '0;
      end
    end else begin
      count_q <= count_d;
      if (bus.redirect_valid) begin
        rdPtr_q   <= '0;
        wrPtr_q   <= '0;
        fetchPc_q <= {bus.redirect_pc[XLEN-1:2], 2'b00};
        // A request accepted now (or still outstanding) is stale and must be
        // drained; a response arriving now closes the stale transaction.
        case (state_q)
          IDLE:    state_q <= REQ;
          REQ:     state_q <= accept ? DRAIN : REQ;
          WAIT:    state_q <= rspValid ? REQ : DRAIN;
          DRAIN:   state_q <= rspValid ? REQ : DRAIN;
          default: state_q <= IDLE;
        endcase
      end else begin
        if (pop) begin
          rdPtr_q <= rdPtr_q + PTR_W'(1);
        end
        if (push) begin
          dataMem_q[wrPtr_q] <= bus.mem_rsp_data;
          pcMem_q[wrPtr_q]   <= reqPc_q;
          wrPtr_q            <= wrPtr_q + PTR_W'(1);
        end
        case (state_q)
          IDLE: begin
            if (count_q < DEPTH_C) begin
              state_q <= REQ;
            end
          end
          REQ: begin
            if (accept) begin
              reqPc_q   <= fetchPc_q;
              fetchPc_q <= fetchPc_q + XLEN'(4);
              state_q   <= WAIT;
            end
          end
          WAIT: begin
            // Entering REQ only with a free slot keeps the FIFO from overflowing.
            if (rspValid) begin
              state_q <= (count_d < DEPTH_C) ? REQ : IDLE;
            end
          end
          DRAIN: begin
            if (rspValid) begin
              state_q <= REQ;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: a memory responder with
// configurable wait states, a transaction-level model of the instruction
// stream checked every cycle, and directed scenarios with literal expectations.
module tb_instr_fetch_unit;

  localparam int          XLEN     = 32;
  localparam logic [31:0] RESET_PC = 32'h0001_0000;
  localparam int          DEPTH    = 4;

  logic clk;
  logic rst_n;

  instr_fetch_if #(.XLEN(XLEN)) bus ();

  instr_fetch_unit #(
    .XLEN    (XLEN),
    .RESET_PC(RESET_PC),
    .DEPTH   (DEPTH)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int assertCount = 0;
  int failCount   = 0;

  // Memory responder configuration, written by the directed sequence.
  int rspDelay      = 1;
  int holdLowCycles = 0;
  int holdGen       = 0;

  // Written only by the compare process.
  int          acceptEvents   = 0;
  logic [31:0] lastAcceptAddr = '0;
  logic [31:0] acceptLog [$];
  logic [31:0] popLog    [$];

  // Model: queue of PCs decode must see, and outstanding requests tagged with
  // the redirect epoch they were issued in.
  logic [31:0] fifoQ  [$];
  logic [31:0] tagPcQ [$];
  int          tagEpQ [$];
  int          epoch    = 0;
  logic [31:0] reqExp   = RESET_PC;
  bit          prevHeld = 0;
  logic [31:0] prevAddr = '0;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_0013;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Memory: one response per accepted request, rspDelay cycles after the
  // first WAIT cycle; ready held low for holdLowCycles requesting cycles.
  initial begin
    int          seenAccept;
    int          seenHold;
    int          holdLeft;
    int          timer;
    bit          pend;
    logic [31:0] pAddr;
    seenAccept = 0;
    seenHold   = 0;
    holdLeft   = 0;
    timer      = 0;
    pend       = 0;
    pAddr      = '0;
    bus.mem_req_ready = 1'b1;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_data  = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.mem_rsp_valid = 1'b0;
      if (!rst_n) begin
        pend       = 0;
        seenAccept = acceptEvents;
      end else begin
        if (acceptEvents != seenAccept) begin
          seenAccept = acceptEvents;
          pend       = 1;
          timer      = rspDelay;
          pAddr      = lastAcceptAddr;
        end
        if (pend) begin
          if (timer == 0) begin
            bus.mem_rsp_valid = 1'b1;
            bus.mem_rsp_data  = memWord(pAddr);
            pend              = 0;
          end else begin
            timer--;
          end
        end
      end
      if (holdGen != seenHold) begin
        seenHold = holdGen;
        holdLeft = holdLowCycles;
      end
      bus.mem_req_ready = (holdLeft == 0);
      if (holdLeft != 0 && bus.mem_req_valid) holdLeft--;
    end
  end

  // Compare process: checks outputs mid-cycle, then advances the model with
  // the handshakes that the coming rising edge will perform.
  always @(negedge clk) begin
    bit          accept;
    bit          rsp;
    bit          pop;
    bit          redir;
    logic [31:0] pc;
    int          ep;
    if (!rst_n) begin
      fifoQ.delete();
      tagPcQ.delete();
      tagEpQ.delete();
      epoch    = 0;
      reqExp   = RESET_PC;
      prevHeld = 0;
    end else begin
      checkOutput("instr_valid", bus.instr_valid, fifoQ.size() != 0);
      if (fifoQ.size() != 0) begin
        checkOutput("instr_pc", bus.instr_pc, fifoQ[0]);
        checkOutput("instr_data", bus.instr_data, memWord(fifoQ[0]));
      end
      if (tagPcQ.size() != 0) checkOutput("req_while_outstanding", bus.mem_req_valid, 0);
      if (prevHeld) begin
        checkOutput("req_hold_valid", bus.mem_req_valid, 1);
        checkOutput("req_hold_addr", bus.mem_req_addr, prevAddr);
      end

      accept   = bus.mem_req_valid && bus.mem_req_ready;
      rsp      = bus.mem_rsp_valid;
      pop      = bus.instr_valid && bus.instr_ready;
      redir    = bus.redirect_valid;
      prevHeld = bus.mem_req_valid && !bus.mem_req_ready && !redir;
      prevAddr = bus.mem_req_addr;

      if (pop && fifoQ.size() != 0) begin
        popLog.push_back(fifoQ[0]);
        void'(fifoQ.pop_front());
      end
      if (rsp && tagPcQ.size() != 0) begin
        pc = tagPcQ.pop_front();
        ep = tagEpQ.pop_front();
        if (ep == epoch && !redir) fifoQ.push_back(pc);
      end
      if (accept) begin
        checkOutput("req_addr", bus.mem_req_addr, reqExp);
        tagPcQ.push_back(reqExp);
        tagEpQ.push_back(epoch);
        acceptLog.push_back(bus.mem_req_addr);
        lastAcceptAddr = bus.mem_req_addr;
        acceptEvents++;
        reqExp = reqExp + 32'd4;
      end
      if (redir) begin
        epoch++;
        fifoQ.delete();
        reqExp = {bus.redirect_pc[31:2], 2'b00};
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input bit ready, input bit redir, input logic [31:0] pc);
    bus.instr_ready    = ready;
    bus.redirect_valid = redir;
    bus.redirect_pc    = pc;
  endtask

  task automatic pulseRedirect(input logic [31:0] pc);
    applyStimulus(bus.instr_ready, 1'b1, pc);
    tick();
    applyStimulus(bus.instr_ready, 1'b0, pc);
  endtask

  task automatic waitAccept(input string name);
    bit found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      if (bus.mem_req_valid && bus.mem_req_ready) found = 1;
      else tick();
    end
    if (!found) checkOutput(name, 0, 1);
  endtask

  task automatic waitRsp(input string name);
    bit found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      if (bus.mem_rsp_valid) found = 1;
      else tick();
    end
    if (!found) checkOutput(name, 0, 1);
  endtask

  task automatic waitPops(input int n, input string name);
    for (int i = 0; i < 100 && popLog.size() < n; i++) tick();
    if (popLog.size() < n) checkOutput(name, popLog.size(), n);
  endtask

  task automatic waitAccepts(input int n, input string name);
    for (int i = 0; i < 100 && acceptLog.size() < n; i++) tick();
    if (acceptLog.size() < n) checkOutput(name, acceptLog.size(), n);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_mem_req_valid"}, bus.mem_req_valid, 0);
    checkOutput({tag, "_mem_req_addr"}, bus.mem_req_addr, RESET_PC);
    checkOutput({tag, "_instr_valid"}, bus.instr_valid, 0);
    checkOutput({tag, "_instr_data"}, bus.instr_data, 0);
    checkOutput({tag, "_instr_pc"}, bus.instr_pc, 0);
  endtask

  initial begin
    int a0;
    int p0;
    int aIdx;
    int pIdx;
    bit seenReq;

    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b0, '0);
    #1 rst_n = 1'b0;
    #1 checkResetOutputs("reset");
    repeat (3) tick();

    // Sequential fetch with one wait state on the response.
    $display("[TB] sequential fetch");
    rst_n = 1'b1;
    tick();
    checkOutput("first_req_valid", bus.mem_req_valid, 1);
    checkOutput("first_req_addr", bus.mem_req_addr, 32'h0001_0000);
    waitPops(3, "seq_pop_timeout");
    checkOutput("seq_pop0", popLog[0], 32'h0001_0000);
    checkOutput("seq_pop1", popLog[1], 32'h0001_0004);
    checkOutput("seq_pop2", popLog[2], 32'h0001_0008);
    a0 = acceptEvents;
    p0 = popLog.size();
    repeat (30) tick();
    checkOutput("throughput_accepts", acceptEvents - a0, 10);
    checkOutput("throughput_pops", popLog.size() - p0, 10);

    // Decode stalled: FIFO fills, then one pop frees exactly one slot.
    $display("[TB] backpressure");
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, '0);
    tick();
    tick();
    rst_n = 1'b1;
    a0 = acceptEvents;
    repeat (40) tick();
    checkOutput("full_accepts", acceptEvents - a0, 4);
    checkOutput("full_req_valid", bus.mem_req_valid, 0);
    checkOutput("full_head_pc", bus.instr_pc, 32'h0001_0000);
    applyStimulus(1'b1, 1'b0, '0);
    tick();
    applyStimulus(1'b0, 1'b0, '0);
    repeat (20) tick();
    checkOutput("one_pop_accepts", acceptEvents - a0, 5);
    checkOutput("one_pop_head_pc", bus.instr_pc, 32'h0001_0004);
    checkOutput("one_pop_req_valid", bus.mem_req_valid, 0);

    // Memory stalls: ready low for 5 requesting cycles, response 7 cycles late.
    $display("[TB] memory wait states");
    holdLowCycles = 5;
    holdGen++;
    rspDelay = 7;
    pulseRedirect(32'h0000_3000);
    for (int i = 0; i < 5; i++) begin
      checkOutput("stall_req_valid", bus.mem_req_valid, 1);
      checkOutput("stall_req_addr", bus.mem_req_addr, 32'h0000_3000);
      tick();
    end
    checkOutput("stall_release_ready", bus.mem_req_ready, 1);
    tick();
    seenReq = 0;
    for (int i = 0; i < 7; i++) begin
      if (bus.mem_req_valid) seenReq = 1;
      tick();
    end
    checkOutput("slow_rsp_no_req", seenReq, 0);
    checkOutput("slow_rsp_arrives", bus.mem_rsp_valid, 1);
    tick();
    checkOutput("after_rsp_req_valid", bus.mem_req_valid, 1);
    checkOutput("after_rsp_req_addr", bus.mem_req_addr, 32'h0000_3004);
    checkOutput("after_rsp_head_pc", bus.instr_pc, 32'h0000_3000);

    // Redirect while waiting for a response.
    $display("[TB] redirect in WAIT");
    applyStimulus(1'b1, 1'b0, '0);
    rspDelay = 5;
    waitAccept("wait_accept_timeout");
    tick();
    tick();
    pulseRedirect(32'h0000_2003);
    checkOutput("drain_instr_valid", bus.instr_valid, 0);
    checkOutput("drain_req_valid", bus.mem_req_valid, 0);
    aIdx = acceptLog.size();
    pIdx = popLog.size();
    waitPops(pIdx + 1, "redirect_pop_timeout");
    checkOutput("redirect_req_addr", acceptLog[aIdx], 32'h0000_2000);
    checkOutput("redirect_first_pc", popLog[pIdx], 32'h0000_2000);

    // Redirect coinciding with the response: no DRAIN.
    $display("[TB] redirect with response");
    rspDelay = 2;
    waitAccept("rsp_accept_timeout");
    tick();
    waitRsp("rsp_wait_timeout");
    applyStimulus(1'b1, 1'b1, 32'h0000_4000);
    tick();
    applyStimulus(1'b1, 1'b0, '0);
    checkOutput("rsp_redirect_req_valid", bus.mem_req_valid, 1);
    checkOutput("rsp_redirect_req_addr", bus.mem_req_addr, 32'h0000_4000);
    checkOutput("rsp_redirect_instr_valid", bus.instr_valid, 0);

    // Redirect in the request handshake cycle: the accepted request is stale.
    $display("[TB] redirect with handshake");
    waitAccept("hs_accept_timeout");
    pulseRedirect(32'h0000_5000);
    checkOutput("hs_drain_req_valid", bus.mem_req_valid, 0);
    aIdx = acceptLog.size();
    pIdx = popLog.size();
    waitPops(pIdx + 1, "hs_pop_timeout");
    checkOutput("hs_req_addr", acceptLog[aIdx], 32'h0000_5000);
    checkOutput("hs_first_pc", popLog[pIdx], 32'h0000_5000);

    // Address wrap at the top of the address space.
    $display("[TB] pc wrap");
    rspDelay = 1;
    pulseRedirect(32'hFFFF_FFFC);
    aIdx = acceptLog.size();
    waitAccepts(aIdx + 2, "wrap_accept_timeout");
    checkOutput("wrap_req0", acceptLog[aIdx], 32'hFFFF_FFFC);
    checkOutput("wrap_req1", acceptLog[aIdx + 1], 32'h0000_0000);

    // Asynchronous reset in the middle of a transaction.
    $display("[TB] async reset mid-WAIT");
    applyStimulus(1'b0, 1'b0, '0);
    repeat (7) tick();
    waitAccept("reset_accept_timeout");
    tick();
    checkOutput("pre_reset_instr_valid", bus.instr_valid, 1);
    #1 rst_n = 1'b0;
    #1 checkResetOutputs("async_reset");
    tick();
    tick();
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b0, '0);
    tick();
    checkOutput("post_reset_req_valid", bus.mem_req_valid, 1);
    checkOutput("post_reset_req_addr", bus.mem_req_addr, RESET_PC);
    repeat (30) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
